// File: rtl/fpu_cmp_writeback.sv
// Registered writeback stage behind the FPU comparator.
// It applies NaN rules, raises the NV flag and buffers results in a small FIFO.
// Optional: define FPU_CMP_CANON_NAN_EN to canonicalise NaN results of fmin/fmax.
module fpu_cmp_writeback #(
    parameter int unsigned Std   = 31,
    parameter int unsigned Exp   = 7,
    parameter int unsigned Man   = 22,
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [7:0]     opcode,
    input  logic [Std:0]   op_a,
    input  logic [Std:0]   op_b,
    input  logic [31:0]    cmp_result,
    input  logic [Std:0]   minmax_result,
    input  logic [4:0]     rd_addr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic [4:0]     out_rd,
    output logic           out_is_fp,
    output logic           out_nv,
    input  logic           fflags_clr,
    output logic           fflags_nv
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        is_fp;
        logic        nv;
    } wb_entry_t;

    wb_entry_t        r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_fflags_nv;

    logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic             w_any_nan, w_any_snan;
    logic [31:0]      w_minmax;
    wb_entry_t        w_entry;
    wb_entry_t        w_head;
    logic             w_push, w_pop;
    logic             w_unused_sign;

    // Operand classification: NaN = exponent all-ones with non-zero mantissa.
    assign w_a_nan    = (&op_a[Std-1 -: Exp+1]) && (|op_a[Man:0]);
    assign w_b_nan    = (&op_b[Std-1 -: Exp+1]) && (|op_b[Man:0]);
    assign w_a_snan   = w_a_nan && !op_a[Man];
    assign w_b_snan   = w_b_nan && !op_b[Man];
    assign w_any_nan  = w_a_nan | w_b_nan;
    assign w_any_snan = w_a_snan | w_b_snan;
    assign w_unused_sign = op_a[Std] ^ op_b[Std];

    always_comb begin
        w_minmax = 32'(minmax_result);
`ifdef FPU_CMP_CANON_NAN_EN
        if (w_a_nan && w_b_nan) begin
            w_minmax = CANON_NAN;
        end else if (w_a_nan) begin
            w_minmax = 32'(op_b);
        end else if (w_b_nan) begin
            w_minmax = 32'(op_a);
        end
`endif
    end

    // Result/flag generation; the lowest set opcode bit selects the operation.
    always_comb begin
        w_entry       = '0;
        w_entry.rd    = rd_addr;
        casez (opcode)
            8'b???????1: begin
                w_entry.data = w_any_nan ? 32'd0 : 32'(|cmp_result);
                w_entry.nv   = w_any_snan;
            end
            8'b??????10: begin
                w_entry.data = w_any_nan ? 32'd1 : 32'(|cmp_result);
                w_entry.nv   = w_any_snan;
            end
            8'b?????100, 8'b????1000, 8'b???10000, 8'b??100000: begin
                w_entry.data = w_any_nan ? 32'd0 : 32'(|cmp_result);
                w_entry.nv   = w_any_nan;
            end
            8'b?1000000, 8'b10000000: begin
                w_entry.data  = w_minmax;
                w_entry.is_fp = 1'b1;
                w_entry.nv    = w_any_snan;
            end
            default: begin
                w_entry.data = 32'd0;
            end
        endcase
    end

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_head    = r_mem[r_rd_ptr];
    assign out_data  = w_head.data;
    assign out_rd    = w_head.rd;
    assign out_is_fp = w_head.is_fp;
    assign out_nv    = w_head.nv;
    assign fflags_nv = r_fflags_nv;

    // Storage is cleared on reset so the head reads as zero when empty after reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky NV: a flagged push wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_fflags_nv <= 1'b0;
        end else if (w_push && w_entry.nv) begin
            r_fflags_nv <= 1'b1;
        end else if (fflags_clr) begin
            r_fflags_nv <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fpu_cmp_writeback.sv
// Directed bench for fpu_cmp_writeback; expectations follow FPU_CMP_CANON_NAN_EN when defined.
module tb_fpu_cmp_writeback;

    logic        clk;
    logic        rst_l;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] cmp_result;
    logic [31:0] minmax_result;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_is_fp;
    logic        out_nv;
    logic        fflags_clr;
    logic        fflags_nv;

    int n_checks;
    int n_errors;

    fpu_cmp_writeback dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .opcode        (opcode),
        .op_a          (op_a),
        .op_b          (op_b),
        .cmp_result    (cmp_result),
        .minmax_result (minmax_result),
        .rd_addr       (rd_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_is_fp     (out_is_fp),
        .out_nv        (out_nv),
        .fflags_clr    (fflags_clr),
        .fflags_nv     (fflags_nv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] cmp, input logic [31:0] mm, input logic [4:0] rd);
        in_valid      = 1'b1;
        opcode        = op;
        op_a          = a;
        op_b          = b;
        cmp_result    = cmp;
        minmax_result = mm;
        rd_addr       = rd;
    endtask

    // One-cycle push; inputs return to idle after the edge.
    task automatic push(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] cmp, input logic [31:0] mm, input logic [4:0] rd);
        drive(op, a, b, cmp, mm, rd);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_fmax;
        logic [31:0] exp_fmin;
`ifdef FPU_CMP_CANON_NAN_EN
        exp_fmax = 32'h4040_0000;
        exp_fmin = 32'h7FC0_0000;
`else
        exp_fmax = 32'h7F80_0001;
        exp_fmin = 32'h7FC0_0001;
`endif
        n_checks      = 0;
        n_errors      = 0;
        rst_l         = 1'b0;
        in_valid      = 1'b0;
        opcode        = 8'h00;
        op_a          = 32'h0;
        op_b          = 32'h0;
        cmp_result    = 32'h0;
        minmax_result = 32'h0;
        rd_addr       = 5'd0;
        out_ready     = 1'b1;
        fflags_clr    = 1'b0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_rd",    32'(out_rd),    32'd0);
        chk("rst_fflags",    32'(fflags_nv), 32'd0);
        rst_l = 1'b1;
        step();

        // flt 1.0 < 2.0
        push(8'h04, 32'h3F80_0000, 32'h4000_0000, 32'd1, 32'd0, 5'd5);
        chk("flt_valid", 32'(out_valid), 32'd1);
        chk("flt_data",  out_data,       32'd1);
        chk("flt_rd",    32'(out_rd),    32'd5);
        chk("flt_is_fp", 32'(out_is_fp), 32'd0);
        chk("flt_nv",    32'(out_nv),    32'd0);

        // fle with qNaN: forced 0, signalling compare raises NV
        push(8'h08, 32'h7FC0_0000, 32'h3F80_0000, 32'd1, 32'd0, 5'd6);
        chk("fle_nan_data",   out_data,       32'd0);
        chk("fle_nan_nv",     32'(out_nv),    32'd1);
        chk("fle_nan_fflags", 32'(fflags_nv), 32'd1);
        chk("fle_nan_rd",     32'(out_rd),    32'd6);

        // feq with qNaN: quiet compare, no NV
        push(8'h01, 32'h7FC0_0000, 32'h3F80_0000, 32'd1, 32'd0, 5'd7);
        chk("feq_nan_data", out_data,    32'd0);
        chk("feq_nan_nv",   32'(out_nv), 32'd0);

        // fne+flt bits set: fne (lower bit) wins, NaN -> 1
        push(8'h06, 32'h3F80_0000, 32'h7FC0_0000, 32'd0, 32'd0, 5'd8);
        chk("fne_prio_data", out_data,    32'd1);
        chk("fne_prio_nv",   32'(out_nv), 32'd0);

        // feq with sNaN raises NV
        push(8'h01, 32'h7F80_0001, 32'h3F80_0000, 32'd0, 32'd0, 5'd9);
        chk("feq_snan_nv", 32'(out_nv), 32'd1);

        // fmax with sNaN operand
        push(8'h80, 32'h7F80_0001, 32'h4040_0000, 32'd0, 32'h7F80_0001, 5'd10);
        chk("fmax_snan_data",  out_data,       exp_fmax);
        chk("fmax_snan_nv",    32'(out_nv),    32'd1);
        chk("fmax_snan_is_fp", 32'(out_is_fp), 32'd1);

        // fmin with both qNaN
        push(8'h40, 32'h7FC0_0000, 32'h7FC0_0000, 32'd0, 32'h7FC0_0001, 5'd11);
        chk("fmin_qnan_data", out_data,    exp_fmin);
        chk("fmin_qnan_nv",   32'(out_nv), 32'd0);

        // opcode 0 still pushes a zero result
        push(8'h00, 32'h7F80_0001, 32'h3F80_0000, 32'd1, 32'h1234_5678, 5'd12);
        chk("op0_valid", 32'(out_valid), 32'd1);
        chk("op0_data",  out_data,       32'd0);
        chk("op0_is_fp", 32'(out_is_fp), 32'd0);
        chk("op0_nv",    32'(out_nv),    32'd0);
        chk("op0_rd",    32'(out_rd),    32'd12);
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // sticky clear, then clear racing a flagged push, then clear alone
        fflags_clr = 1'b1;
        step();
        chk("clr_alone_a", 32'(fflags_nv), 32'd0);
        push(8'h80, 32'h7F80_0001, 32'h4040_0000, 32'd0, 32'h4040_0000, 5'd13);
        chk("clr_vs_set", 32'(fflags_nv), 32'd1);
        chk("clr_vs_set_nv", 32'(out_nv), 32'd1);
        step();
        chk("clr_alone_b", 32'(fflags_nv), 32'd0);
        fflags_clr = 1'b0;

        // backpressure: two pushes fill, third is refused
        out_ready = 1'b0;
        push(8'h04, 32'h3F80_0000, 32'h4000_0000, 32'd1, 32'd0, 5'd1);
        chk("bp_ready_1", 32'(in_ready), 32'd1);
        push(8'h04, 32'h4000_0000, 32'h3F80_0000, 32'd0, 32'd0, 5'd2);
        chk("bp_ready_2", 32'(in_ready), 32'd0);
        push(8'h04, 32'h3F80_0000, 32'h4000_0000, 32'd1, 32'd0, 5'd3);
        chk("bp_head_rd", 32'(out_rd),   32'd1);
        chk("bp_head_d",  out_data,      32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_drain_rd",  32'(out_rd),    32'd2);
        chk("bp_drain_d",   out_data,       32'd0);
        chk("bp_drain_vld", 32'(out_valid), 32'd1);
        step();
        chk("bp_empty_vld", 32'(out_valid), 32'd0);
        chk("bp_empty_rdy", 32'(in_ready),  32'd1);

        // reset while two entries are held and NV is sticky
        out_ready = 1'b0;
        push(8'h08, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 32'd0, 5'd20);
        push(8'h04, 32'h3F80_0000, 32'h4000_0000, 32'd1, 32'd0, 5'd21);
        chk("pre_rst_full",   32'(in_ready),  32'd0);
        chk("pre_rst_fflags", 32'(fflags_nv), 32'd1);
        rst_l = 1'b0;
        step();
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_fflags", 32'(fflags_nv), 32'd0);
        chk("mid_rst_data",   out_data,       32'd0);
        rst_l     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
